// File: rtl/button_event_ctrl_pkg.sv
// btn_event_pkg: command kinds, hold-timer phases and ownership states for button_event_ctrl.
package btn_event_pkg;
  localparam logic [1:0] KIND_PRESS   = 2'd0;
  localparam logic [1:0] KIND_REPEAT  = 2'd1;
  localparam logic [1:0] KIND_RELEASE = 2'd2;
  typedef enum logic {PH_HOLD, PH_REPEAT} phase_e;
  typedef enum logic {ST_IDLE, ST_OWNED} own_e;
endpackage

// File: rtl/button_event_ctrl_if.sv
// button_event_ctrl_if: valid/ready command channel carrying button id and event kind.
interface button_event_ctrl_if #(parameter int ID_W = 2);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [ID_W-1:0] cmd_id;
  logic [1:0]      cmd_kind;
  modport master(output cmd_valid, cmd_id, cmd_kind, input cmd_ready);
  modport slave(input cmd_valid, cmd_id, cmd_kind, output cmd_ready);
endinterface

// File: rtl/button_event_ctrl_hold_timer.sv
// hold_timer: shared hold/auto-repeat counter; rep_tick_o pulses once per elapsed hold or repeat period.
module hold_timer import btn_event_pkg::*; #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic stop_i,
  output logic rep_tick_o
);
  localparam int CW = $clog2(HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES);
  // The start edge itself is the first hold cycle, so the hold phase ends one count earlier.
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 2);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  phase_e        phase_q, phase_d;
  logic          run_q, run_d;
  always_comb begin
    rep_tick_o = run_q && !stop_i && cnt_q == (phase_q == PH_HOLD ? HOLD_LAST : REP_LAST);
    run_d      = start_i || (run_q && !stop_i);
    cnt_d      = (start_i || rep_tick_o) ? '0 : run_q ? cnt_q + CW'(1) : cnt_q;
    phase_d    = start_i ? PH_HOLD : rep_tick_o ? PH_REPEAT : phase_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= PH_HOLD;
      run_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      run_q   <= run_d;
    end
endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns debounced button levels into a serialized PRESS/REPEAT/RELEASE stream
// with per-button pending bits, one shared repeat timer owned by a single button, and a priority arbiter.
module button_event_ctrl import btn_event_pkg::*; #(
  parameter int N_BTN         = 4,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_BTN-1:0]     btn_clean,
  button_event_ctrl_if.master  cmd,
  output logic                 overflow
);
  localparam int ID_W = $clog2(N_BTN);
  logic [N_BTN-1:0] btn_q, p_press_q, p_press_d, p_rep_q, p_rep_d, p_rel_q, p_rel_d;
  logic [N_BTN-1:0] rise, fall, any, sel, rep_set, clr_press, clr_rep, clr_rel;
  logic [ID_W-1:0]  win, rise_low, owner_q, owner_d, id_q, id_d;
  logic [1:0]       kind_q, kind_d;
  logic             valid_q, valid_d, ovf_q, ovf_d, ld, start, stop, tick;
  own_e             state_q, state_d;

  assign rise = btn_clean & ~btn_q;
  assign fall = ~btn_clean & btn_q;
  assign any  = p_press_q | p_rep_q | p_rel_q;
  assign ld   = !valid_q || cmd.cmd_ready;
  assign sel  = (ld && (|any)) ? N_BTN'(1) << win : '0;

  always_comb begin
    win      = '0;
    rise_low = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (any[i]) win = ID_W'(i);
      if (rise[i]) rise_low = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    start   = 1'b0;
    stop    = 1'b0;
    if (state_q == ST_IDLE && (|rise)) begin
      state_d = ST_OWNED;
      owner_d = rise_low;
      start   = 1'b1;
    end else if (state_q == ST_OWNED && fall[owner_q]) begin
      state_d = ST_IDLE;
      stop    = 1'b1;
    end
  end

  // A bit being loaded this cycle is free again, so a same-kind event refills it rather than dropping.
  always_comb begin
    rep_set   = tick ? N_BTN'(1) << owner_q : '0;
    clr_press = sel & p_press_q;
    clr_rep   = sel & ~p_press_q & p_rep_q;
    clr_rel   = sel & ~p_press_q & ~p_rep_q;
    p_press_d = p_press_q & ~clr_press | rise;
    p_rep_d   = (p_rep_q & ~clr_rep | rep_set) & ~fall;
    p_rel_d   = p_rel_q & ~clr_rel | fall;
    ovf_d     = ovf_q || (|(rise & p_press_q & ~clr_press)) || (|(fall & p_rel_q & ~clr_rel));
    valid_d   = ld ? (|any) : valid_q;
    id_d      = (ld && (|any)) ? win : id_q;
    kind_d    = (ld && (|any)) ? (p_press_q[win] ? KIND_PRESS : p_rep_q[win] ? KIND_REPEAT : KIND_RELEASE) : kind_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      btn_q     <= '0;
      p_press_q <= '0;
      p_rep_q   <= '0;
      p_rel_q   <= '0;
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      kind_q    <= KIND_PRESS;
      ovf_q     <= 1'b0;
    end else begin
      btn_q     <= btn_clean;
      p_press_q <= p_press_d;
      p_rep_q   <= p_rep_d;
      p_rel_q   <= p_rel_d;
      state_q   <= state_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      kind_q    <= kind_d;
      ovf_q     <= ovf_d;
    end

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start),
    .stop_i     (stop),
    .rep_tick_o (tick)
  );

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_id    = id_q;
  assign cmd.cmd_kind  = kind_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed stimulus with a cycle-stamped expected-command queue checked by a monitor.
module tb_button_event_ctrl;
  import btn_event_pkg::*;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn = '0;
  logic       ovf;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         freeze_chk = 1'b0;
  typedef struct { int id; int kind; int cyc; } exp_t;
  exp_t sb[$];

  button_event_ctrl_if #(.ID_W(2)) cmd_if();
  button_event_ctrl #(.N_BTN(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_clean (btn),
    .cmd       (cmd_if),
    .overflow  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e_id, input int e_kind, input int e_cyc);
    sb.push_back('{e_id, e_kind, e_cyc});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    step(2);
  endtask

  always @(negedge clk) begin
    if (freeze_chk)
      chk("freeze", 32'({cmd_if.cmd_valid, cmd_if.cmd_id, cmd_if.cmd_kind}), 32'b10000);
    if (reset_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cmd: unexpected id %0d kind %0d at cyc %0d", cmd_if.cmd_id, cmd_if.cmd_kind, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (cmd_if.cmd_id !== 2'(e.id) || cmd_if.cmd_kind !== 2'(e.kind) || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL cmd: got id %0d kind %0d at cyc %0d, want id %0d kind %0d at cyc %0d",
                   cmd_if.cmd_id, cmd_if.cmd_kind, cyc, e.id, e.kind, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    cmd_if.cmd_ready = 1'b1;
    step(2);
    chk("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("rst_id", 32'(cmd_if.cmd_id), 32'd0);
    chk("rst_kind", 32'(cmd_if.cmd_kind), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    step(2);
    // tap button 2
    btn = 4'b0100;
    push(2, KIND_PRESS, cyc + 2);
    step(3);
    btn = 4'b0000;
    push(2, KIND_RELEASE, cyc + 2);
    drain();
    chk("tap_ovf", 32'(ovf), 32'd0);
    // hold button 0: three repeats, none after the fall
    btn = 4'b0001;
    t = cyc;
    push(0, KIND_PRESS, t + 2);
    push(0, KIND_REPEAT, t + 9);
    push(0, KIND_REPEAT, t + 13);
    push(0, KIND_REPEAT, t + 17);
    step(18);
    btn = 4'b0000;
    push(0, KIND_RELEASE, cyc + 2);
    drain();
    // simultaneous 3 and 1: owner 1 repeats, 3 does not
    btn = 4'b1010;
    t = cyc;
    push(1, KIND_PRESS, t + 2);
    push(3, KIND_PRESS, t + 3);
    push(1, KIND_REPEAT, t + 9);
    step(10);
    btn = 4'b0000;
    push(1, KIND_RELEASE, cyc + 2);
    push(3, KIND_RELEASE, cyc + 3);
    drain();
    // repeats coalesce while the consumer stalls
    cmd_if.cmd_ready = 1'b0;
    btn = 4'b0001;
    t = cyc;
    step(17);
    cmd_if.cmd_ready = 1'b1;
    btn = 4'b0000;
    push(0, KIND_PRESS, t + 17);
    push(0, KIND_REPEAT, t + 18);
    push(0, KIND_RELEASE, t + 19);
    drain();
    chk("coalesce_ovf", 32'(ovf), 32'd0);
    // stalled output stays frozen; re-press of button 1 is dropped
    cmd_if.cmd_ready = 1'b0;
    btn = 4'b0001;
    step(2);
    freeze_chk = 1'b1;
    btn = 4'b0000;
    step(2);
    btn = 4'b0010;
    step(2);
    btn = 4'b0000;
    step(2);
    chk("ovf_before_drop", 32'(ovf), 32'd0);
    btn = 4'b0010;
    step(2);
    chk("ovf_after_drop", 32'(ovf), 32'd1);
    btn = 4'b0000;
    step(2);
    freeze_chk = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    t = cyc;
    push(0, KIND_PRESS, t);
    push(0, KIND_RELEASE, t + 1);
    push(1, KIND_PRESS, t + 2);
    push(1, KIND_RELEASE, t + 3);
    drain();
    chk("ovf_sticky", 32'(ovf), 32'd1);
    // reset mid-operation with button 2 held
    cmd_if.cmd_ready = 1'b0;
    btn = 4'b1100;
    step(3);
    chk("pre_rst_valid", 32'(cmd_if.cmd_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("mid_rst_id", 32'(cmd_if.cmd_id), 32'd0);
    chk("mid_rst_kind", 32'(cmd_if.cmd_kind), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    btn = 4'b0100;
    step(2);
    reset_n = 1'b1;
    cmd_if.cmd_ready = 1'b1;
    push(2, KIND_PRESS, cyc + 2);
    step(2);
    btn = 4'b0000;
    push(2, KIND_RELEASE, cyc + 2);
    drain();
    chk("final_ovf", 32'(ovf), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Event controller that sits behind a bank of debouncer instances in the counter design. It turns N debounced button levels into a single serialized command stream: PRESS, REPEAT (auto-repeat while held) and RELEASE. Commands are delivered over a valid/ready handshake to the counter control logic. One hold/repeat timer is shared among the buttons and arbitrated by ownership.

## Interface
- `N_BTN`, 4: number of debounced inputs (2..8).
- `HOLD_CYCLES`, 50_000_000: cycles held before the first REPEAT (~500 ms @ 100 MHz).
- `REPEAT_CYCLES`, 10_000_000: cycles between subsequent REPEATs (~100 ms).

Ports:
- `clk` input 1: system clock. One clock only.
- `reset_n` input 1: reset, asynchronous, active-low.
- `btn_clean` input N_BTN: debounced levels, 1 = pressed.
- `cmd_valid` output 1: a command is presented.
- `cmd_ready` input 1: consumer accepts the command this cycle.
- `cmd_id` output $clog2(N_BTN): index of the button the command refers to.
- `cmd_kind` output 2: 0 = PRESS, 1 = REPEAT, 2 = RELEASE; 3 is never driven.
- `overflow` output 1: sticky. Set when an event is dropped; cleared only by reset.

## Operation
- `btn_q` registers `btn_clean` every cycle. A rise is `btn_clean & ~btn_q`; a fall is `~btn_clean & btn_q`.
- Each button has three pending bits: `p_press`, `p_rep`, `p_rel`.
- Rise on button i:
  - If `p_press[i]` is already set, the event is dropped and `overflow` is set.
  - Otherwise `p_press[i]` is set.
- Fall on button i:
  - `p_rel[i]` is set.
  - `p_rep[i]` is cleared, so stale repeats are discarded.
  - If `p_rel[i]` is already set, the event is dropped and `overflow` is set.
- Hold timer (shared):
  - States are IDLE and OWNED(owner).
  - In IDLE, a rise on any button makes the lowest rising index the owner. The count is reset to 0 and the phase to HOLD.
  - In OWNED, the count increments each cycle.
    - At HOLD_CYCLES-1 in phase HOLD: set `p_rep[owner]`, count becomes 0, phase becomes REPEAT.
    - At REPEAT_CYCLES-1 in phase REPEAT: set `p_rep[owner]`, count becomes 0.
  - A fall on the owner returns the timer to IDLE in the same cycle.
  - Rises on non-owners while OWNED still produce PRESS and RELEASE events but never REPEAT.
- REPEAT coalescing: if `p_rep` is already set when a new REPEAT is generated, the new one merges silently. This is not an overflow.
- Output arbitration:
  - The output register loads when `!cmd_valid || cmd_ready`.
  - The winner is the lowest button index with any pending bit.
  - Within a button the order is PRESS, then REPEAT, then RELEASE.
  - The winning pending bit is cleared in the same cycle it is loaded.
  - If nothing is pending at load time, `cmd_valid` goes to 0.
- A pending bit set and loaded in the same cycle is cleared, unless a new event of the same kind arrives in that cycle. In that case it stays set.
- Reset values: `cmd_valid`=0, `cmd_id`=0, `cmd_kind`=0, `overflow`=0, `btn_q`=0, all pending bits 0, timer IDLE. A button held through reset therefore yields a PRESS after release of reset.
- Reset asserted mid-operation discards all pending and in-flight commands immediately.

## Timing
- Latency is 2 clock edges. If `btn_clean` changes before edge 0, the pending bit is set at edge 0 and `cmd_valid`/`cmd_id`/`cmd_kind` are valid after edge 1, provided the output is idle.
- Handshake:
  - The transfer occurs on an edge where `cmd_valid && cmd_ready`.
  - While `cmd_valid && !cmd_ready`, `cmd_id` and `cmd_kind` hold stable.
- Back-to-back transfers run at one per cycle while events are pending.
- Timing of REPEATs for button i, with the rise pending at edge 0:
  - First REPEAT is pending at edge HOLD_CYCLES-1.
  - Each subsequent REPEAT is pending REPEAT_CYCLES edges later.
- `overflow` rises on the edge of the dropped event.

## Structure
- Package `btn_event_pkg` holds:
  - KIND_PRESS=2'd0, KIND_REPEAT=2'd1, KIND_RELEASE=2'd2;
  - the timer phase encoding (PH_HOLD, PH_REPEAT);
  - the IDLE/OWNED encoding.
- Sub-module `hold_timer` holds the shared counter and phase logic.
  - Inputs: start, stop.
  - Output: a single-cycle `rep_tick` pulse.
  - Counter width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
- Edge detection, pending bits, ownership and the output arbiter live in the top module.
- The bench overrides HOLD_CYCLES=8 and REPEAT_CYCLES=4.

## Test plan
- Tap button 2 for 3 cycles with `cmd_ready`=1 -> PRESS(id 2) valid 2 edges after the rise, RELEASE(id 2) afterwards; no REPEAT; `overflow`=0.
- Hold button 0 for 20 cycles -> PRESS, then REPEAT at rise+8, rise+12, rise+16, then RELEASE. No REPEAT after the fall.
- Press buttons 3 and 1 in the same cycle -> PRESS(1) then PRESS(3) on consecutive cycles. The timer owner is 1, so only button 1 repeats.
- Hold `cmd_ready`=0 while pressing, releasing and re-pressing button 1 -> `cmd_id`/`cmd_kind` stay frozen. The second rise is dropped and `overflow`=1. After `cmd_ready`=1 the stream is PRESS(1), RELEASE(1).
- Hold button 0 with `cmd_ready`=0 across 3 repeat periods -> a single coalesced REPEAT is delivered and `overflow` stays 0.
- Assert `reset_n`=0 with commands pending and button 2 held -> all outputs go to 0 immediately. After reset is released, a PRESS(2) appears 2 edges later.
